// File: rtl/configurable_clock_gating.sv
// Glitch-free clock gate passing one of every N rising edges of clk_in, N chosen at run time.
// A low-phase latch holds the gate request so gated_clk only ever shows full clk_in high phases.
module configurable_clock_gating #(
  parameter  int MAX_MULTIPLIER = 4,
  localparam int MW             = (MAX_MULTIPLIER > 1) ? $clog2(MAX_MULTIPLIER) : 1
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          enable,
  input  logic [MW-1:0] multiplier,
  output logic          gated_clk
);

  logic [MW-1:0] r_cnt;
  logic [MW-1:0] r_n_cur;
  logic          r_latch_q;

  logic [MW-1:0] w_n_dec;
  logic [MW:0]   w_cnt_inc;
  logic          w_wrap;
  logic          w_gate_req;

  // A zero ratio select means "no division".
  assign w_n_dec = (multiplier == '0) ? MW'(1) : multiplier;

  // Extra bit keeps the compare safe when n_cur is still garbage after power-up.
  assign w_cnt_inc = {1'b0, r_cnt} + (MW+1)'(1);
  assign w_wrap    = w_cnt_inc >= {1'b0, r_n_cur};

  assign w_gate_req = enable & ~rst & (r_cnt == '0);

  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst || !enable || w_wrap) begin
      r_cnt   <= '0;
      r_n_cur <= w_n_dec;
    end else begin
      r_cnt   <= w_cnt_inc[MW-1:0];
    end
  end

  // NOTE: this latch is intentional; it is transparent only while clk_in is low, so the
  // request is frozen for the whole high phase and gated_clk cannot be clipped or glitched.
  always_latch begin
    if (!clk_in) r_latch_q <= w_gate_req;
  end

  assign gated_clk = clk_in & r_latch_q;

endmodule

// File: tb/tb_configurable_clock_gating.sv
// Directed bench for configurable_clock_gating: per-high-phase expectations go through a
// scoreboard queue; a separate monitor checks every gated_clk pulse is one full clk_in high phase.
module tb_configurable_clock_gating;

  localparam int MAX_MULTIPLIER = 4;
  localparam int MW = (MAX_MULTIPLIER > 1) ? $clog2(MAX_MULTIPLIER) : 1;

  logic          clk_in = 1'b0;
  logic          rst;
  logic          enable;
  logic [MW-1:0] multiplier;
  logic          gated_clk;

  int   n_checks = 0;
  int   n_fails  = 0;
  bit   sb[$];
  time  t_rise;
  bit   seen_rise = 0;

  configurable_clock_gating #(.MAX_MULTIPLIER(MAX_MULTIPLIER)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .enable     (enable),
    .multiplier (multiplier),
    .gated_clk  (gated_clk)
  );

  // Rising edges at 5, 15, 25 ... ; falling edges at 10, 20, 30 ...
  always #5 clk_in = ~clk_in;

  // Drive one low phase of inputs and queue the expected gated_clk for the next high phase.
  task automatic step(input bit r, input bit e, input int m, input bit exp);
    @(negedge clk_in);
    #1;
    rst        = r;
    enable     = e;
    multiplier = MW'(m);
    sb.push_back(exp);
  endtask

  task automatic drop_enable_in_high();
    @(posedge clk_in);
    #1;
    enable = 1'b0;
  endtask

  // Scoreboard: mid high phase must match the queued value, mid low phase must be 0.
  always @(posedge clk_in) begin
    bit exp;
    #2;
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      n_checks++;
      assert (gated_clk === exp) else begin
        n_fails++;
        $error("FAIL high_phase t=%0t got=%b exp=%b", $time, gated_clk, exp);
      end
      #5;
      n_checks++;
      assert (gated_clk === 1'b0) else begin
        n_fails++;
        $error("FAIL low_phase t=%0t got=%b exp=0", $time, gated_clk);
      end
    end
  end

  // Glitch checks: rises only on clk_in rising edges, every pulse exactly 5 ns.
  always @(posedge gated_clk) begin
    t_rise    = $time;
    seen_rise = 1;
    n_checks++;
    assert (clk_in === 1'b1 && ($time % 10) == 5) else begin
      n_fails++;
      $error("FAIL rise_align t=%0t got_clk=%b exp_clk=1 at t%%10==5", $time, clk_in);
    end
  end

  always @(negedge gated_clk) begin
    if (seen_rise) begin
      n_checks++;
      assert (($time - t_rise) == 5) else begin
        n_fails++;
        $error("FAIL pulse_width t=%0t got=%0t exp=5", $time, $time - t_rise);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    multiplier = MW'(2);

    // Reset held two cycles with enable=1, N=2: no pulses.
    step(1, 1, 2, 0);
    step(1, 1, 2, 0);
    // Release: immediate pulse, then every 20 ns.
    step(0, 1, 2, 1);
    step(0, 1, 2, 0);
    step(0, 1, 2, 1);
    step(0, 1, 2, 0);
    step(0, 1, 2, 1);
    // Change to N=3 mid-count: current 20 ns interval completes, then every 30 ns.
    step(0, 1, 3, 0);
    step(0, 1, 3, 1);
    step(0, 1, 3, 0);
    step(0, 1, 3, 0);
    step(0, 1, 3, 1);
    step(0, 1, 3, 0);
    step(0, 1, 3, 0);
    step(0, 1, 3, 1);
    // multiplier=1 taken at the next wrap, then gated_clk tracks clk_in.
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 1);
    step(0, 1, 1, 1);
    step(0, 1, 1, 1);
    // multiplier=0 decodes to N=1 as well.
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    // Back to N=2, then drop enable in the middle of a pulse.
    step(0, 1, 2, 1);
    step(0, 1, 2, 1);
    step(0, 1, 2, 0);
    step(0, 1, 2, 1);
    drop_enable_in_high();
    step(0, 0, 2, 0);
    step(0, 0, 2, 0);
    // Re-enable in a low phase: full pulse right away.
    step(0, 1, 2, 1);
    step(0, 1, 2, 0);
    step(0, 1, 2, 1);
    // N=3, reset when cnt=1: low during reset, immediate pulse after, then every 30 ns.
    step(0, 1, 3, 0);
    step(0, 1, 3, 1);
    step(1, 1, 3, 0);
    step(1, 1, 3, 0);
    step(0, 1, 3, 1);
    step(0, 1, 3, 0);
    step(0, 1, 3, 0);
    step(0, 1, 3, 1);
    step(0, 1, 3, 0);
    step(0, 1, 3, 0);
    step(0, 1, 3, 1);

    @(posedge clk_in);
    #9;
    n_checks++;
    assert (sb.size() == 0) else begin
      n_fails++;
      $error("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
